lookup_engine_pipe: RTL and testbench
=====================================

Name: lookup_engine_pipe

Overview:
- Parametrised, fully pipelined match-action lookup stage, one per RMT pipeline stage; sits between the key extractor and the action engine.
- Holds a runtime-writable ternary match table (value/mask/valid per entry) and an action table.
- Accepts one key per cycle under valid/ready backpressure.
- Returns the action of the lowest-index matching entry, or a programmable default on miss, together with the PHV.

Parameters:
- STAGE, 0, pipeline stage index; informational only.
- PHV_LEN, 1124, PHV width in bits.
- KEY_LEN, 197, match key width.
- ACT_LEN, 625, action word width.
- DEPTH, 16, number of entries; any value 2..64.
- ADDR_W, $clog2(DEPTH), entry address width.
- DEFAULT_ACT, 625'h3f, action emitted on miss.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key_in  in  KEY_LEN  lookup key
- key_valid  in  1  key/PHV valid
- key_ready  out  1  engine can accept a key
- phv_in  in  PHV_LEN  PHV accompanying key
- action  out  ACT_LEN  resolved action
- phv_out  out  PHV_LEN  PHV aligned with action
- hit  out  1  1 = table hit, 0 = default action
- hit_addr  out  ADDR_W  matching entry; 0 on miss
- action_valid  out  1  output valid
- action_ready  in  1  downstream accepts output
- tcam_wr_en  in  1  write match entry
- tcam_wr_addr  in  ADDR_W  entry index
- tcam_wr_key  in  KEY_LEN  entry value
- tcam_wr_mask  in  KEY_LEN  1 = don't-care bit
- tcam_wr_vld  in  1  entry valid bit written
- act_wr_en  in  1  write action word
- act_wr_addr  in  ADDR_W  action index
- act_wr_data  in  ACT_LEN  action data

Behaviour:
- Pipeline enable: adv = ~action_valid | action_ready. key_ready = adv. Accept = key_valid & adv.
- S1, on accept: register key, PHV and valid. When adv=1 and key_valid=0, S1 valid <= 0.
- Compare, combinational on S1 key: entry i matches if vld[i] & (((key ^ val[i]) & ~mask[i]) == 0). The lowest matching index wins.
- S2 (on adv): register hit, addr, PHV and valid.
- Output (on adv):
  - action <= hit ? act_ram[addr] : DEFAULT_ACT.
  - hit_addr <= hit ? addr : 0.
  - phv_out, hit and action_valid load from S2.
- Timing:
  - Latency: 2 cycles from accept edge to action_valid, with no stall.
  - Throughput: 1 lookup per cycle.
- Stall: with action_valid=1 and action_ready=0, all stages hold and outputs stay stable. No loss or duplication.
- Write timing:
  - A TCAM write takes effect at its edge.
  - A compare in the same cycle as a write uses the old contents.
  - An S2 result frozen by a stall is not re-evaluated.
- Action read/write conflict: the action read is performed in the cycle the output register loads. A same-cycle act_wr to that address returns the old data (read-before-write).
- Write addresses >= DEPTH are ignored.
- Reset: all entry valid bits 0; val, mask and act_ram 0. All pipeline valids 0. Outputs reset as follows:
  - action 0, phv_out 0, hit 0, hit_addr 0, action_valid 0.
  - key_ready 1 (follows adv).
- Reset mid-operation flushes in-flight lookups. No output appears for them.
- An empty table (all invalid) gives a miss, i.e. DEFAULT_ACT.

Optional Feature:
- Macro: LOOKUP_HIT_CNT_EN.
- With the macro: ports cnt_rd_addr (in, ADDR_W), cnt_rd_data (out, 32) and miss_cnt (out, 32) are added.
  - One 32-bit saturating counter per entry. It increments when the output register loads a valid hit for that entry.
  - miss_cnt increments on valid misses.
  - cnt_rd_data is registered, 1-cycle read latency.
  - A tcam_wr to an entry clears its counter; the clear wins over a same-cycle increment.
  - All counters reset to 0.
- Without the macro: these ports and the counter logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package lookup_pkg: KEY_LEN, ACT_LEN, PHV_LEN defaults, DEFAULT_ACT, counter width 32.
- Sub-module tcam_prio_match: entry storage with write port, plus parallel compare and lowest-index priority encoder. Outputs combinational hit/addr.
- act_ram array, pipeline registers and counters stay in the top level.

Test Plan:
- Empty table, key 197'h5 -> 2 cycles later action=625'h3f, hit=0, hit_addr=0, phv_out=phv_in.
- Entry 3 val=5 mask=0 act=0xAA; entry 7 val=0 mask=all-ones act=0xBB.
  - Key 5 -> hit_addr=3, action 0xAA.
  - Key 9 -> hit_addr=7, action 0xBB.
- 16 back-to-back keys with action_ready=1 -> 16 outputs on consecutive cycles, in order, PHVs aligned.
- action_ready held 0 for 5 cycles mid-stream -> outputs stable, key_ready=0, no drop or duplicate after release.
- TCAM write clearing vld of entry 3 in the same cycle as a key-5 compare -> that lookup hits 3; the next key-5 lookup misses.
- LOOKUP_HIT_CNT_EN: 4 hits on entry 3 and 2 misses -> cnt_rd_data(3)=4, miss_cnt=2. Rewriting entry 3 -> cnt_rd_data(3)=0.

Source files
------------

// File: rtl/lookup_pkg.sv
// Shared widths, default action and counter helpers for the match-action lookup stage.
package lookup_pkg;

    localparam int KEY_LEN_DEF = 197;
    localparam int ACT_LEN_DEF = 625;
    localparam int PHV_LEN_DEF = 1124;
    localparam logic [ACT_LEN_DEF-1:0] DEFAULT_ACT_DEF = 625'h3f;
    localparam int CNT_W = 32;

    // Saturating increment: a counter that reaches all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/lookup_engine_pipe_tcam.sv
// Ternary match table with write port, parallel compare and lowest-index priority encoder.
module tcam_prio_match
    import lookup_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int KEY_LEN = KEY_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [KEY_LEN-1:0] wr_key,
    input  logic [KEY_LEN-1:0] wr_mask,
    input  logic               wr_vld,
    input  logic [KEY_LEN-1:0] key,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);

    logic [KEY_LEN-1:0] val_q  [DEPTH];
    logic [KEY_LEN-1:0] val_d  [DEPTH];
    logic [KEY_LEN-1:0] mask_q [DEPTH];
    logic [KEY_LEN-1:0] mask_d [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [DEPTH-1:0]   vld_d;
    logic [DEPTH-1:0]   match;

    // Per-index decode means addresses beyond the table simply select nothing.
    always_comb begin
        val_d  = val_q;
        mask_d = mask_q;
        vld_d  = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                val_d[i]  = wr_key;
                mask_d[i] = wr_mask;
                vld_d[i]  = wr_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i]  <= '0;
                mask_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            val_q  <= val_d;
            mask_q <= mask_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_q[i] && (((key ^ val_q[i]) & ~mask_q[i]) == '0);
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit  = 1'b0;
        addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit  = 1'b1;
                addr = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/lookup_engine_pipe.sv
// Pipelined match-action lookup stage: S1 key register, S2 match result, output action register.
// Optional per-entry hit and miss counters are built when LOOKUP_HIT_CNT_EN is defined.
module lookup_engine_pipe
    import lookup_pkg::*;
#(
    parameter int STAGE   = 0,
    parameter int PHV_LEN = PHV_LEN_DEF,
    parameter int KEY_LEN = KEY_LEN_DEF,
    parameter int ACT_LEN = ACT_LEN_DEF,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter logic [ACT_LEN-1:0] DEFAULT_ACT = ACT_LEN'(DEFAULT_ACT_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [PHV_LEN-1:0] phv_in,
    output logic [ACT_LEN-1:0] action,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               hit,
    output logic [ADDR_W-1:0]  hit_addr,
    output logic               action_valid,
    input  logic               action_ready,
    input  logic               tcam_wr_en,
    input  logic [ADDR_W-1:0]  tcam_wr_addr,
    input  logic [KEY_LEN-1:0] tcam_wr_key,
    input  logic [KEY_LEN-1:0] tcam_wr_mask,
    input  logic               tcam_wr_vld,
    input  logic               act_wr_en,
    input  logic [ADDR_W-1:0]  act_wr_addr,
    input  logic [ACT_LEN-1:0] act_wr_data
`ifdef LOOKUP_HIT_CNT_EN
    ,
    input  logic [ADDR_W-1:0]  cnt_rd_addr,
    output logic [CNT_W-1:0]   cnt_rd_data,
    output logic [CNT_W-1:0]   miss_cnt
`endif
);

    if (DEPTH < 2 || DEPTH > 64 || STAGE < 0) begin : g_bad_param
        $error("lookup_engine_pipe: DEPTH must lie in 2..64 and STAGE must be non-negative");
    end

    logic adv;
    logic tcam_hit;
    logic [ADDR_W-1:0] tcam_addr;

    logic               s1_valid_q, s1_valid_d;
    logic [KEY_LEN-1:0] s1_key_q, s1_key_d;
    logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;
    logic               s2_valid_q, s2_valid_d;
    logic               s2_hit_q, s2_hit_d;
    logic [ADDR_W-1:0]  s2_addr_q, s2_addr_d;
    logic [PHV_LEN-1:0] s2_phv_q, s2_phv_d;
    logic [ACT_LEN-1:0] action_q, action_d;
    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic               hit_q, hit_d;
    logic [ADDR_W-1:0]  hit_addr_q, hit_addr_d;
    logic               action_valid_q, action_valid_d;
    logic [ACT_LEN-1:0] act_ram_q [DEPTH];
    logic [ACT_LEN-1:0] act_ram_d [DEPTH];

    assign adv       = ~action_valid_q | action_ready;
    assign key_ready = adv;

    tcam_prio_match #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .KEY_LEN (KEY_LEN)
    ) u_tcam (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tcam_wr_en),
        .wr_addr (tcam_wr_addr),
        .wr_key  (tcam_wr_key),
        .wr_mask (tcam_wr_mask),
        .wr_vld  (tcam_wr_vld),
        .key     (s1_key_q),
        .hit     (tcam_hit),
        .addr    (tcam_addr)
    );

    // The whole pipe moves together on adv; the action read uses the pre-write RAM contents.
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_key_d       = s1_key_q;
        s1_phv_d       = s1_phv_q;
        s2_valid_d     = s2_valid_q;
        s2_hit_d       = s2_hit_q;
        s2_addr_d      = s2_addr_q;
        s2_phv_d       = s2_phv_q;
        action_d       = action_q;
        phv_out_d      = phv_out_q;
        hit_d          = hit_q;
        hit_addr_d     = hit_addr_q;
        action_valid_d = action_valid_q;
        act_ram_d      = act_ram_q;
        if (adv) begin
            s1_valid_d = key_valid;
            if (key_valid) begin
                s1_key_d = key_in;
                s1_phv_d = phv_in;
            end
            s2_valid_d     = s1_valid_q;
            s2_hit_d       = s1_valid_q & tcam_hit;
            s2_addr_d      = tcam_addr;
            s2_phv_d       = s1_phv_q;
            action_valid_d = s2_valid_q;
            hit_d          = s2_hit_q;
            hit_addr_d     = s2_hit_q ? s2_addr_q : '0;
            action_d       = s2_hit_q ? act_ram_q[s2_addr_q] : DEFAULT_ACT;
            phv_out_d      = s2_phv_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (act_wr_en && (act_wr_addr == ADDR_W'(i))) begin
                act_ram_d[i] = act_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_key_q       <= '0;
            s1_phv_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_hit_q       <= 1'b0;
            s2_addr_q      <= '0;
            s2_phv_q       <= '0;
            action_q       <= '0;
            phv_out_q      <= '0;
            hit_q          <= 1'b0;
            hit_addr_q     <= '0;
            action_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                act_ram_q[i] <= '0;
            end
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_key_q       <= s1_key_d;
            s1_phv_q       <= s1_phv_d;
            s2_valid_q     <= s2_valid_d;
            s2_hit_q       <= s2_hit_d;
            s2_addr_q      <= s2_addr_d;
            s2_phv_q       <= s2_phv_d;
            action_q       <= action_d;
            phv_out_q      <= phv_out_d;
            hit_q          <= hit_d;
            hit_addr_q     <= hit_addr_d;
            action_valid_q <= action_valid_d;
            act_ram_q      <= act_ram_d;
        end
    end

    assign action       = action_q;
    assign phv_out      = phv_out_q;
    assign hit          = hit_q;
    assign hit_addr     = hit_addr_q;
    assign action_valid = action_valid_q;

`ifdef LOOKUP_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q [DEPTH];
    logic [CNT_W-1:0] hit_cnt_d [DEPTH];
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] cnt_rd_data_q, cnt_rd_data_d;

    // Counters advance exactly when the output register loads a valid result; a rewrite clears.
    always_comb begin
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        cnt_rd_data_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_rd_addr == ADDR_W'(i)) begin
                cnt_rd_data_d = hit_cnt_q[i];
            end
            if (tcam_wr_en && (tcam_wr_addr == ADDR_W'(i))) begin
                hit_cnt_d[i] = '0;
            end else if (adv && s2_valid_q && s2_hit_q && (s2_addr_q == ADDR_W'(i))) begin
                hit_cnt_d[i] = sat_inc(hit_cnt_q[i]);
            end
        end
        if (adv && s2_valid_q && !s2_hit_q) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit_cnt_q[i] <= '0;
            end
            miss_cnt_q    <= '0;
            cnt_rd_data_q <= '0;
        end else begin
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            cnt_rd_data_q <= cnt_rd_data_d;
        end
    end

    assign cnt_rd_data = cnt_rd_data_q;
    assign miss_cnt    = miss_cnt_q;
`endif

endmodule

// File: tb/tb_lookup_engine_pipe.sv
// Directed, table-driven bench for lookup_engine_pipe; counter checks build with LOOKUP_HIT_CNT_EN.
module tb_lookup_engine_pipe;
    import lookup_pkg::*;

    localparam int KEY_LEN = KEY_LEN_DEF;
    localparam int ACT_LEN = ACT_LEN_DEF;
    localparam int PHV_LEN = PHV_LEN_DEF;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam logic [ACT_LEN-1:0] ACT_DEF = 625'h3f;
    localparam logic [ACT_LEN-1:0] ACT_AA  = 625'hAA;
    localparam logic [ACT_LEN-1:0] ACT_BB  = 625'hBB;
    localparam logic [ACT_LEN-1:0] ACT_CC  = 625'hCC;
    localparam logic [ACT_LEN-1:0] ACT_DD  = 625'hDD;

    typedef struct {
        logic [KEY_LEN-1:0] key;
        logic [PHV_LEN-1:0] phv;
        logic               exp_hit;
        logic [ADDR_W-1:0]  exp_addr;
        logic [ACT_LEN-1:0] exp_act;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic [KEY_LEN-1:0] key_in;
    logic               key_valid;
    logic               key_ready;
    logic [PHV_LEN-1:0] phv_in;
    logic [ACT_LEN-1:0] action;
    logic [PHV_LEN-1:0] phv_out;
    logic               hit;
    logic [ADDR_W-1:0]  hit_addr;
    logic               action_valid;
    logic               action_ready;
    logic               tcam_wr_en;
    logic [ADDR_W-1:0]  tcam_wr_addr;
    logic [KEY_LEN-1:0] tcam_wr_key;
    logic [KEY_LEN-1:0] tcam_wr_mask;
    logic               tcam_wr_vld;
    logic               act_wr_en;
    logic [ADDR_W-1:0]  act_wr_addr;
    logic [ACT_LEN-1:0] act_wr_data;
`ifdef LOOKUP_HIT_CNT_EN
    logic [ADDR_W-1:0]  cnt_rd_addr;
    logic [CNT_W-1:0]   cnt_rd_data;
    logic [CNT_W-1:0]   miss_cnt;
`endif

    vec_t vecs [32];
    vec_t one_vec;
    int   n_checks;
    int   n_errors;

    lookup_engine_pipe #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .phv_in       (phv_in),
        .action       (action),
        .phv_out      (phv_out),
        .hit          (hit),
        .hit_addr     (hit_addr),
        .action_valid (action_valid),
        .action_ready (action_ready),
        .tcam_wr_en   (tcam_wr_en),
        .tcam_wr_addr (tcam_wr_addr),
        .tcam_wr_key  (tcam_wr_key),
        .tcam_wr_mask (tcam_wr_mask),
        .tcam_wr_vld  (tcam_wr_vld),
        .act_wr_en    (act_wr_en),
        .act_wr_addr  (act_wr_addr),
        .act_wr_data  (act_wr_data)
`ifdef LOOKUP_HIT_CNT_EN
        ,
        .cnt_rd_addr  (cnt_rd_addr),
        .cnt_rd_data  (cnt_rd_data),
        .miss_cnt     (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkInt(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        n_checks++;
        if (action !== v.exp_act) begin
            n_errors++;
            $display("[TB] FAIL %s.action got %h expected %h", name, action[63:0], v.exp_act[63:0]);
        end
        n_checks++;
        if (hit !== v.exp_hit || hit_addr !== v.exp_addr) begin
            n_errors++;
            $display("[TB] FAIL %s.hit got %0b/%0d expected %0b/%0d", name, hit, hit_addr, v.exp_hit, v.exp_addr);
        end
        n_checks++;
        if (phv_out !== v.phv) begin
            n_errors++;
            $display("[TB] FAIL %s.phv got %h expected %h", name, phv_out[63:0], v.phv[63:0]);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p);
        key_valid = vld;
        key_in    = k;
        phv_in    = p;
    endtask

    task automatic programEntry(input int a, input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] m,
                                input logic v, input logic act_en, input logic [ACT_LEN-1:0] act);
        @(negedge clk);
        tcam_wr_en   = 1'b1;
        tcam_wr_addr = ADDR_W'(a);
        tcam_wr_key  = k;
        tcam_wr_mask = m;
        tcam_wr_vld  = v;
        act_wr_en    = act_en;
        act_wr_addr  = ADDR_W'(a);
        act_wr_data  = act;
        @(negedge clk);
        tcam_wr_en = 1'b0;
        act_wr_en  = 1'b0;
    endtask

    // Streams vecs[first +: n]; optionally holds action_ready low for 5 cycles once stall_at results are out.
    task automatic runStream(input string name, input int first, input int n, input int stall_at);
        int in_j, out_j, cyc, stall_left, acc_cyc, out_cyc;
        in_j = 0; out_j = 0; cyc = 0; acc_cyc = -1; out_cyc = -1;
        stall_left = (stall_at >= 0) ? 5 : 0;
        while (out_j < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            action_ready = !(stall_at >= 0 && out_j == stall_at && stall_left > 0);
            if (in_j < n) applyStimulus(1'b1, vecs[first+in_j].key, vecs[first+in_j].phv);
            else          applyStimulus(1'b0, '0, '0);
            #1;
            if (!action_ready) begin
                stall_left--;
                checkInt({name, ".stall_key_ready"}, longint'(key_ready), 0);
                checkInt({name, ".stall_valid"}, longint'(action_valid), 1);
                checkOutput({name, ".stall_hold"}, vecs[first+out_j]);
            end else if (action_valid) begin
                if (out_j == 0) out_cyc = cyc;
                checkOutput(name, vecs[first+out_j]);
                out_j++;
            end else if (out_j > 0) begin
                checkInt({name, ".consecutive"}, longint'(action_valid), 1);
            end
            if (key_ready && in_j < n) begin
                if (in_j == 0) acc_cyc = cyc;
                in_j++;
            end
        end
        if (out_j < n) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL %s.timeout got %0d results expected %0d", name, out_j, n);
        end
        // Accept edge follows negedge acc_cyc; the result is visible three negedges later.
        if (stall_at < 0 && out_cyc >= 0) checkInt({name, ".latency"}, longint'(out_cyc - acc_cyc), 3);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        action_ready = 1'b1;
        #1;
        checkInt({name, ".no_dup"}, longint'(action_valid), 0);
    endtask

    function automatic vec_t mkVec(input logic [KEY_LEN-1:0] k, input int tag, input logic h,
                                   input int a, input logic [ACT_LEN-1:0] act);
        vec_t v;
        v.key = k;
        v.phv = '0;
        v.phv[63:0] = 64'hF00D_0000_0000_0000 + 64'(tag);
        v.phv[PHV_LEN-1 -: 8] = 8'(tag + 1);
        v.exp_hit  = h;
        v.exp_addr = ADDR_W'(a);
        v.exp_act  = act;
        return v;
    endfunction

    initial begin
        logic [KEY_LEN-1:0] ones;
        n_checks = 0;
        n_errors = 0;
        ones = '1;

        // Entries: 3 = exact 5 -> AA, 1 = 0x1? -> CC, 7 = catch-all -> BB.
        vecs[0]  = mkVec(197'h5, 0, 1'b0, 0, ACT_DEF);
        vecs[1]  = mkVec(197'h5, 1, 1'b1, 3, ACT_AA);
        vecs[2]  = mkVec(197'h9, 2, 1'b1, 7, ACT_BB);
        vecs[3]  = mkVec(197'h0, 3, 1'b1, 7, ACT_BB);
        vecs[4]  = mkVec(197'h13, 4, 1'b1, 1, ACT_CC);
        vecs[5]  = mkVec(197'h1F, 5, 1'b1, 1, ACT_CC);
        vecs[6]  = mkVec(197'h23, 6, 1'b1, 7, ACT_BB);
        vecs[7]  = mkVec(197'h4, 7, 1'b1, 7, ACT_BB);
        vecs[8]  = mkVec(197'h5, 8, 1'b1, 3, ACT_AA);
        vecs[9]  = mkVec(197'h10, 9, 1'b1, 1, ACT_CC);
        vecs[10] = mkVec(197'h15, 10, 1'b1, 1, ACT_CC);
        vecs[11] = mkVec(197'h7, 11, 1'b1, 7, ACT_BB);
        vecs[12] = mkVec(197'h5, 12, 1'b1, 3, ACT_AA);
        vecs[13] = mkVec(197'h1_0000_0005, 13, 1'b1, 7, ACT_BB);
        vecs[14] = mkVec(ones, 14, 1'b1, 7, ACT_BB);
        vecs[15] = mkVec(197'h1A, 15, 1'b1, 1, ACT_CC);
        vecs[16] = mkVec(197'h5, 16, 1'b1, 3, ACT_AA);
        for (int i = 17; i < 21; i++) vecs[i] = mkVec(197'h5, i, 1'b1, 3, ACT_AA);
        vecs[21] = mkVec(197'h9, 21, 1'b0, 0, ACT_DEF);
        vecs[22] = mkVec(197'h9, 22, 1'b0, 0, ACT_DEF);
        vecs[23] = mkVec(197'h5, 23, 1'b0, 0, ACT_DEF);
        vecs[24] = mkVec(197'h13, 24, 1'b1, 1, ACT_CC);

        rst_n = 1'b0;
        action_ready = 1'b1;
        applyStimulus(1'b0, '0, '0);
        tcam_wr_en = 1'b0; tcam_wr_addr = '0; tcam_wr_key = '0; tcam_wr_mask = '0; tcam_wr_vld = 1'b0;
        act_wr_en = 1'b0; act_wr_addr = '0; act_wr_data = '0;
`ifdef LOOKUP_HIT_CNT_EN
        cnt_rd_addr = '0;
`endif
        repeat (3) @(negedge clk);
        one_vec = vecs[0];
        one_vec.phv = '0;
        one_vec.exp_act = '0;
        checkOutput("reset", one_vec);
        checkInt("reset.valid", longint'(action_valid), 0);
        checkInt("reset.key_ready", longint'(key_ready), 1);
        rst_n = 1'b1;

        $display("[TB] empty table lookup");
        runStream("empty", 0, 1, -1);

        programEntry(3, 197'h5, '0, 1'b1, 1'b1, ACT_AA);
        programEntry(7, '0, ones, 1'b1, 1'b1, ACT_BB);
        programEntry(1, 197'h10, 197'hF, 1'b1, 1'b1, ACT_CC);

        $display("[TB] back-to-back stream");
        runStream("stream", 1, 16, -1);
        $display("[TB] stream with downstream stall");
        runStream("stall", 1, 16, 6);

        programEntry(7, '0, ones, 1'b0, 1'b0, '0);

`ifdef LOOKUP_HIT_CNT_EN
        $display("[TB] hit and miss counters");
        programEntry(3, 197'h5, '0, 1'b1, 1'b0, '0);
        runStream("counters", 17, 6, -1);
        cnt_rd_addr = 4'd3;
        @(negedge clk);
        checkInt("cnt_rd_data_3", longint'(cnt_rd_data), 4);
        checkInt("miss_cnt", longint'(miss_cnt), 3);
        programEntry(3, 197'h5, '0, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkInt("cnt_cleared_3", longint'(cnt_rd_data), 0);
`endif

        $display("[TB] write in flight with a lookup");
        one_vec = mkVec(197'h5, 30, 1'b1, 3, ACT_AA);
        @(negedge clk);
        applyStimulus(1'b1, one_vec.key, one_vec.phv);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        tcam_wr_en = 1'b1; tcam_wr_addr = 4'd3; tcam_wr_key = 197'h5; tcam_wr_mask = '0; tcam_wr_vld = 1'b0;
        @(negedge clk);
        tcam_wr_en = 1'b0;
        act_wr_en = 1'b1; act_wr_addr = 4'd3; act_wr_data = ACT_DD;
        @(negedge clk);
        act_wr_en = 1'b0;
        checkInt("wr_race.valid", longint'(action_valid), 1);
        checkOutput("wr_race", one_vec);
        runStream("after_clear", 23, 2, -1);

        $display("[TB] reset with lookups in flight");
        @(negedge clk);
        applyStimulus(1'b1, 197'h13, vecs[24].phv);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkInt("flush.valid", longint'(action_valid), 0);
        end
        runStream("post_reset_empty", 0, 1, -1);

        $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
